keypad_scan_ctrl: RTL and testbench
===================================

KEYPAD_SCAN_CTRL -- requirements
Module: keypad_scan_ctrl

Interface
REQ-001 Parameter SCAN_DIV, default 50000: clk cycles per scan tick (column dwell); legal range is 2 or more.
REQ-002 Parameter DEBOUNCE_CNT, default 4: consecutive identical tick samples needed to accept a press or a release; legal range is 1 to 15.
REQ-003 Parameter REPEAT_CNT, default 250: ticks a key must be held before each auto-repeat event (used only under KEYPAD_REPEAT_EN).
REQ-004 clk  in  1  the single clock; all state changes on its rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-low.
REQ-006 row  in  4  keypad row lines, active-high; asynchronous to clk.
REQ-007 col  out  4  driven column, one-hot, active-high.
REQ-008 key_code  out  4  accepted key = col_idx*4 + row_idx.
REQ-009 key_valid  out  1  key event pending; held until acknowledged.
REQ-010 key_ack  in  1  consumer acknowledge for the pending event.
REQ-011 key_overrun  out  1  sticky flag: an event was lost while one was already pending.

Function
REQ-012 row SHALL pass through a 2-flop synchronizer; all decisions use the synchronized value, sampled only on a scan tick.
REQ-013 A scan tick SHALL occur once every SCAN_DIV clk cycles, counting from reset release.
REQ-014 FSM states SHALL be: SCAN, DEBOUNCE, PRESSED, RELEASE.
REQ-015 SCAN, tick with sample zero: col rotates 0001->0010->0100->1000->0001.
REQ-016 SCAN, tick with nonzero sample: col holds, the sample is latched, count=1, go to DEBOUNCE.
REQ-017 DEBOUNCE, tick with sample equal to the latched value: count increments; when count reaches DEBOUNCE_CNT, go to PRESSED.
REQ-018 DEBOUNCE, tick with a differing or zero sample: count clears, return to SCAN with col held.
REQ-019 With DEBOUNCE_CNT=1, the first nonzero sample goes directly to PRESSED.
REQ-020 Multiple row bits set: the lowest set index SHALL be row_idx.
REQ-021 Entering PRESSED SHALL raise key_valid and load key_code on the following clk edge (latency 1 cycle).
REQ-022 PRESSED, tick with zero sample: count=1, go to RELEASE.
REQ-023 RELEASE: DEBOUNCE_CNT consecutive zero samples go to SCAN with col advanced one position; any nonzero sample returns to PRESSED without a new event.
REQ-024 key_valid SHALL clear on the clk edge after key_ack is sampled high; key_ack while key_valid=0 SHALL be ignored.
REQ-025 A new event while key_valid=1 and unacknowledged SHALL set key_overrun; key_code SHALL keep the older value.
REQ-026 Simultaneous new event and key_ack: the ack clears the old event and the new event loads in the same edge; key_valid stays 1 and key_overrun is not set.
REQ-027 key_overrun SHALL clear only on an accepted key_ack or on reset.
REQ-028 col SHALL always be exactly one-hot and SHALL hold while in DEBOUNCE, PRESSED and RELEASE.

Reset
REQ-029 rst=0 SHALL immediately force: state=SCAN, col=0001, key_code=0, key_valid=0, key_overrun=0, all counters=0, synchronizer flops=0.
REQ-030 Reset asserted mid-operation SHALL discard any partial debounce or pending event; no event is generated after release.

Configuration
REQ-031 Macro KEYPAD_REPEAT_EN defined: in PRESSED, every REPEAT_CNT ticks with a nonzero sample SHALL issue a new event with the same key_code, subject to REQ-025 and REQ-026.
REQ-032 KEYPAD_REPEAT_EN undefined: exactly one event per press; no repeat counter is built and REPEAT_CNT is ignored.

Structure
REQ-033 Package keypad_pkg SHALL hold the state enum type, the 4-bit key_code type, and the default constants for SCAN_DIV, DEBOUNCE_CNT and REPEAT_CNT.
REQ-034 Sub-module scan_tick_gen SHALL implement the SCAN_DIV divider and produce a 1-cycle tick strobe.

Verification
Bench parameters: SCAN_DIV=4, DEBOUNCE_CNT=3, REPEAT_CNT=8. The keypad model drives row only while the column of the pressed key is driven.
REQ-035 Reset: hold rst=0 for 5 cycles -> col=0001, key_valid=0, key_code=0, key_overrun=0; after release, col reaches 0010 after 4 cycles.
REQ-036 Idle: row=0 for 32 cycles -> col cycles through its 4 values twice; key_valid never rises.
REQ-037 Press: key at col1/row1 (row=0010 when col=0010) -> key_valid=1 with key_code=4'h5 after 3 matching ticks plus 1 cycle; key_ack pulse -> key_valid=0 on the next edge.
REQ-038 Bounce: row toggles every 4 cycles -> no key_valid; col then resumes rotating.
REQ-039 Overrun: press and release key 5, then press key at col3/row0 with no ack -> key_overrun=1 and key_code stays 4'h5; key_ack -> key_overrun=0.
REQ-040 Reset mid-DEBOUNCE (rst=0 pulse after 2 matching ticks) -> col=0001, no event generated; with KEYPAD_REPEAT_EN, key held 8 more ticks after acceptance -> second event with key_code=4'h5.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared types and default constants for the 4x4 keypad scanner.
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN,
        DEBOUNCE,
        PRESSED,
        RELEASE
    } state_t;

    typedef logic [3:0] key_code_t;

    localparam int SCAN_DIV_DEF     = 50000;
    localparam int DEBOUNCE_CNT_DEF = 4;
    localparam int REPEAT_CNT_DEF   = 250;

    // Index of the lowest set bit; used both for the one-hot column and for row priority.
    function automatic logic [1:0] low_idx(input logic [3:0] v);
        if (v[0])      return 2'd0;
        else if (v[1]) return 2'd1;
        else if (v[2]) return 2'd2;
        else           return 2'd3;
    endfunction

endpackage

// File: rtl/scan_tick_gen.sv
// Free-running divider producing a one-cycle tick every SCAN_DIV clk cycles.
module scan_tick_gen
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV = SCAN_DIV_DEF
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int CW = $clog2(SCAN_DIV);
    localparam logic [CW-1:0] LAST = CW'(SCAN_DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/keypad_scan_ctrl.sv
// 4x4 keypad column scanner with debounce and a held-until-ack event register.
// Optional auto-repeat while a key is held is enabled by defining KEYPAD_REPEAT_EN.
module keypad_scan_ctrl
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV     = SCAN_DIV_DEF,
    parameter int DEBOUNCE_CNT = DEBOUNCE_CNT_DEF,
    parameter int REPEAT_CNT   = REPEAT_CNT_DEF
) (
    input  logic      clk,
    input  logic      rst,
    input  logic [3:0] row,
    output logic [3:0] col,
    output key_code_t key_code,
    output logic      key_valid,
    input  logic      key_ack,
    output logic      key_overrun
);

    if (SCAN_DIV < 2 || DEBOUNCE_CNT < 1 || DEBOUNCE_CNT > 15 || REPEAT_CNT < 1) begin : g_bad_param
        $error("keypad_scan_ctrl: parameter out of range");
    end

    localparam logic [3:0] DB_LAST = 4'(DEBOUNCE_CNT);

    logic       tick;
    logic [3:0] row_s1;
    logic [3:0] row_s2;
    logic [3:0] latched;
    logic [3:0] cnt;
    logic [3:0] cnt_nxt;
    state_t     state;
    logic       evt;
    key_code_t  hit_code;

`ifdef KEYPAD_REPEAT_EN
    localparam int RW = $clog2(REPEAT_CNT + 1);
    localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_CNT - 1);
    logic [RW-1:0] rep_cnt;
`endif

    scan_tick_gen #(.SCAN_DIV(SCAN_DIV)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    assign cnt_nxt = cnt + 4'd1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            row_s1      <= '0;
            row_s2      <= '0;
            state       <= SCAN;
            col         <= 4'b0001;
            latched     <= '0;
            cnt         <= '0;
            evt         <= 1'b0;
            hit_code    <= '0;
            key_code    <= '0;
            key_valid   <= 1'b0;
            key_overrun <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
            rep_cnt     <= '0;
`endif
        end else begin
            row_s1 <= row;
            row_s2 <= row_s1;
            evt    <= 1'b0;

            if (tick) begin
                case (state)
                    SCAN: begin
                        if (row_s2 == 4'b0000) begin
                            col <= {col[2:0], col[3]};
                        end else begin
                            latched <= row_s2;
                            if (DB_LAST == 4'd1) begin
                                state    <= PRESSED;
                                evt      <= 1'b1;
                                hit_code <= {low_idx(col), low_idx(row_s2)};
                                cnt      <= '0;
`ifdef KEYPAD_REPEAT_EN
                                rep_cnt  <= '0;
`endif
                            end else begin
                                state <= DEBOUNCE;
                                cnt   <= 4'd1;
                            end
                        end
                    end
                    DEBOUNCE: begin
                        if (row_s2 == latched) begin
                            if (cnt_nxt == DB_LAST) begin
                                state    <= PRESSED;
                                evt      <= 1'b1;
                                hit_code <= {low_idx(col), low_idx(row_s2)};
                                cnt      <= '0;
`ifdef KEYPAD_REPEAT_EN
                                rep_cnt  <= '0;
`endif
                            end else begin
                                cnt <= cnt_nxt;
                            end
                        end else begin
                            state <= SCAN;
                            cnt   <= '0;
                        end
                    end
                    PRESSED: begin
                        if (row_s2 == 4'b0000) begin
                            // The first zero sample already counts toward the release debounce.
                            if (DB_LAST == 4'd1) begin
                                state <= SCAN;
                                col   <= {col[2:0], col[3]};
                                cnt   <= '0;
                            end else begin
                                state <= RELEASE;
                                cnt   <= 4'd1;
                            end
                        end else begin
`ifdef KEYPAD_REPEAT_EN
                            if (rep_cnt == REP_LAST) begin
                                rep_cnt <= '0;
                                evt     <= 1'b1;
                            end else begin
                                rep_cnt <= rep_cnt + 1'b1;
                            end
`endif
                        end
                    end
                    RELEASE: begin
                        if (row_s2 == 4'b0000) begin
                            if (cnt_nxt == DB_LAST) begin
                                state <= SCAN;
                                col   <= {col[2:0], col[3]};
                                cnt   <= '0;
                            end else begin
                                cnt <= cnt_nxt;
                            end
                        end else begin
                            state <= PRESSED;
                            cnt   <= '0;
`ifdef KEYPAD_REPEAT_EN
                            rep_cnt <= '0;
`endif
                        end
                    end
                    default: state <= SCAN;
                endcase
            end

            // An ack in the same cycle as a new event frees the slot for that event.
            if (evt && (!key_valid || key_ack)) begin
                key_code  <= hit_code;
                key_valid <= 1'b1;
            end else if (key_valid && key_ack) begin
                key_valid <= 1'b0;
            end

            if (key_valid && key_ack) begin
                key_overrun <= 1'b0;
            end else if (evt && key_valid) begin
                key_overrun <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Scoreboard bench for keypad_scan_ctrl; the repeat scenario follows KEYPAD_REPEAT_EN.
module tb_keypad_scan_ctrl;

    logic       clk;
    logic       rst;
    logic [3:0] row;
    logic [3:0] col;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_ack;
    logic       key_overrun;

    logic       key_on;
    logic [3:0] key_col;
    logic [3:0] key_row;

    int n_checks = 0;
    int n_pass   = 0;
    logic [3:0] exp_q[$];
    logic prev_valid = 1'b0;

    keypad_scan_ctrl #(
        .SCAN_DIV     (4),
        .DEBOUNCE_CNT (3),
        .REPEAT_CNT   (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .row         (row),
        .col         (col),
        .key_code    (key_code),
        .key_valid   (key_valid),
        .key_ack     (key_ack),
        .key_overrun (key_overrun)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Keypad model: the key closes its row line only while its column is driven.
    always_comb row = (key_on && (col == key_col)) ? key_row : 4'b0000;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    always @(negedge clk) begin
        if (key_valid && !prev_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_event", 32'(key_code) | 32'h100, 32'h0);
            end else begin
                check("event_code", 32'(key_code), 32'(exp_q.pop_front()));
            end
        end
        prev_valid = key_valid;
    end

    task automatic wait_col(input logic [3:0] c, input bit eq, input string name);
        int n = 0;
        while (((col == c) != eq) && n < 64) begin
            @(negedge clk);
            n++;
        end
        if (n >= 64) check(name, 32'(col), 32'(c));
    endtask

    task automatic wait_valid(input int bound, input string name);
        int n = 0;
        while (!key_valid && n < bound) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(key_valid), 32'd1);
    endtask

    task automatic ack_pulse();
        key_ack = 1'b1;
        @(negedge clk);
        key_ack = 1'b0;
    endtask

    task automatic set_key(input logic [3:0] c, input logic [3:0] r);
        key_col = c;
        key_row = r;
    endtask

    initial begin
        logic [3:0] c0;
        logic [3:0] prev;
        int changes;
        int n;

        rst = 1'b0;
        key_ack = 1'b0;
        key_on = 1'b0;
        set_key(4'b0010, 4'b0010);

        repeat (5) @(negedge clk);
        check("rst_col", 32'(col), 32'h1);
        check("rst_valid", 32'(key_valid), 32'h0);
        check("rst_code", 32'(key_code), 32'h0);
        check("rst_overrun", 32'(key_overrun), 32'h0);

        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("col_before_first_tick", 32'(col), 32'h1);
        @(negedge clk);
        check("col_first_tick", 32'(col), 32'h2);

        // Idle: two full rotations in 32 cycles.
        c0 = col;
        prev = col;
        changes = 0;
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            if (col != prev) changes++;
            prev = col;
        end
        check("idle_col_changes", 32'(changes), 32'd8);
        check("idle_col_back", 32'(col), 32'(c0));
        ack_pulse();
        check("idle_ack_ignored_valid", 32'(key_valid), 32'h0);
        check("idle_ack_ignored_ovr", 32'(key_overrun), 32'h0);

        // Press key 5 and time the acceptance from the column edge.
        set_key(4'b0010, 4'b0010);
        wait_col(4'b0010, 1'b0, "press_wait_away");
        key_on = 1'b1;
        exp_q.push_back(4'h5);
        wait_col(4'b0010, 1'b1, "press_wait_col");
        repeat (12) @(negedge clk);
        check("press_not_yet", 32'(key_valid), 32'h0);
        @(negedge clk);
        check("press_valid", 32'(key_valid), 32'h1);
        ack_pulse();
        check("press_ack_clears", 32'(key_valid), 32'h0);
        key_on = 1'b0;
        repeat (24) @(negedge clk);

        // Bounce: key contact toggles every 4 cycles.
        for (int i = 0; i < 12; i++) begin
            key_on = ~key_on;
            repeat (4) @(negedge clk);
        end
        key_on = 1'b0;
        repeat (4) @(negedge clk);
        c0 = col;
        repeat (12) @(negedge clk);
        check("bounce_col_resumes", 32'(col != c0), 32'h1);
        check("bounce_no_valid", 32'(key_valid), 32'h0);

        // Overrun: second key while key 5 is still pending.
        set_key(4'b0010, 4'b0010);
        key_on = 1'b1;
        exp_q.push_back(4'h5);
        wait_valid(80, "ovr_first_valid");
        key_on = 1'b0;
        repeat (24) @(negedge clk);
        set_key(4'b1000, 4'b0001);
        key_on = 1'b1;
        n = 0;
        while (!key_overrun && n < 80) begin
            @(negedge clk);
            n++;
        end
        key_on = 1'b0;
        check("ovr_set", 32'(key_overrun), 32'h1);
        check("ovr_code_kept", 32'(key_code), 32'h5);
        check("ovr_valid_held", 32'(key_valid), 32'h1);
        repeat (24) @(negedge clk);
        ack_pulse();
        check("ovr_ack_clears_ovr", 32'(key_overrun), 32'h0);
        check("ovr_ack_clears_valid", 32'(key_valid), 32'h0);
        repeat (8) @(negedge clk);

        // Reset after two matching ticks in DEBOUNCE.
        set_key(4'b0010, 4'b0010);
        wait_col(4'b0010, 1'b0, "rstmid_wait_away");
        key_on = 1'b1;
        wait_col(4'b0010, 1'b1, "rstmid_wait_col");
        repeat (8) @(negedge clk);
        rst = 1'b0;
        key_on = 1'b0;
        #1;
        check("rstmid_col", 32'(col), 32'h1);
        @(negedge clk);
        rst = 1'b1;
        repeat (40) @(negedge clk);
        check("rstmid_no_event", 32'(key_valid), 32'h0);

        // Hold key 5 well past acceptance.
        set_key(4'b0010, 4'b0010);
        key_on = 1'b1;
        exp_q.push_back(4'h5);
        wait_valid(80, "hold_first_valid");
        ack_pulse();
`ifdef KEYPAD_REPEAT_EN
        exp_q.push_back(4'h5);
        wait_valid(60, "repeat_valid");
        check("repeat_code", 32'(key_code), 32'h5);
        ack_pulse();
`else
        repeat (48) @(negedge clk);
        check("no_repeat", 32'(key_valid), 32'h0);
`endif
        key_on = 1'b0;
        repeat (24) @(negedge clk);

        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
